// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with a ready/valid holding register.
// Frame: start, 8 data bits LSB first, optional parity, one or two stop bits.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, a parity bit follows
// the data bits and is checked. When it is undefined, no parity bit is expected,
// odd_parity is ignored, and parity_err stays 0.
module uart_rx #(
   parameter int BAUD_DIVISOR = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   input  logic       two_stop,
   input  logic       odd_parity,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [13:0] DIV_LAST = 14'(BAUD_DIVISOR - 1);
   localparam logic [13:0] DIV_HALF = 14'(BAUD_DIVISOR / 2);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_e;
`endif

   // Expected parity bit: XOR of the data for even parity, inverted for odd parity.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   logic        sync1_q, sync2_q, rx_prev_q;
   logic        rx_s, edge_s, sample_s, complete_s;

   state_e      state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        cfg_two_q, cfg_two_d;
   logic        ferr_flag_q, ferr_flag_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
   logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic        cfg_odd_q, cfg_odd_d;
   logic        perr_flag_q, perr_flag_d;
   logic        perr_q, perr_d;
`else
   logic        unused_odd_parity_s;
   assign unused_odd_parity_s = odd_parity;
`endif

   assign rx_s     = sync2_q;
   // A start edge is a 1 followed by a 0, so a line held low (break) never re-triggers.
   assign edge_s   = rx_prev_q & ~rx_s;
   assign sample_s = (cnt_q == DIV_LAST);

   // Two-flop synchronizer plus previous-value flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx_in;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   // Next-state logic for the frame FSM, the sampling counters and the holding register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (sample_s) ? 14'd0 : (cnt_q + 14'd1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      cfg_two_d   = cfg_two_q;
      ferr_flag_d = ferr_flag_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ferr_d      = ferr_q;
      ovr_d       = ovr_q;
      complete_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
      cfg_odd_d   = cfg_odd_q;
      perr_flag_d = perr_flag_q;
      perr_d      = perr_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = 14'd0;
            if (edge_s) begin
               state_d     = START;
               bit_d       = 3'd0;
               cfg_two_d   = two_stop;
               ferr_flag_d = 1'b0;
`ifdef UART_RX_PARITY_EN
               cfg_odd_d   = odd_parity;
               perr_flag_d = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == DIV_HALF) begin
               cnt_d   = 14'd0;
               // Mid-start sample: a high line means a glitch, not a frame.
               state_d = (rx_s) ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 14'd1;
            end
         end
         DATA: begin
            if (sample_s) begin
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP1;
`endif
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (sample_s) begin
               perr_flag_d = rx_s ^ parity_bit(shift_q, cfg_odd_q);
               state_d     = STOP1;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP1: begin
            if (sample_s) begin
               ferr_flag_d = ferr_flag_q | ~rx_s;
               if (cfg_two_q) begin
                  state_d = STOP2;
               end else begin
                  state_d    = IDLE;
                  complete_s = 1'b1;
               end
            end else begin
               state_d = STOP1;
            end
         end
         STOP2: begin
            if (sample_s) begin
               ferr_flag_d = ferr_flag_q | ~rx_s;
               state_d     = IDLE;
               complete_s  = 1'b1;
            end else begin
               state_d = STOP2;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 14'd0;
         end
      endcase

      // Holding register: load a finished word, flag overrun, or clear on acceptance.
      if (complete_s) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            ferr_d  = ferr_flag_d;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = perr_flag_q;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end else begin
         valid_d = valid_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 14'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h00;
         cfg_two_q   <= 1'b0;
         ferr_flag_q <= 1'b0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         cfg_odd_q   <= 1'b0;
         perr_flag_q <= 1'b0;
         perr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         cfg_two_q   <= cfg_two_d;
         ferr_flag_q <= ferr_flag_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
         busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
         cfg_odd_q   <= cfg_odd_d;
         perr_flag_q <= perr_flag_d;
         perr_q      <= perr_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIVISOR=16: directed frames plus random frames
// compared against a frame-level reference model.
module tb_uart_rx;

   localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       two_stop = 1'b0;
   logic       odd_parity = 1'b0;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, overrun, busy;

   int checks = 0;
   int errors = 0;
   logic [9:0] got[$];

   uart_rx #(.BAUD_DIVISOR(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .two_stop(two_stop),
      .odd_parity(odd_parity), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record every word accepted by the consumer: {parity_err, frame_err, rx_data}.
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) got.push_back({parity_err, frame_err, rx_data});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx_in = v;
      idle(DIV);
   endtask

   function automatic logic par_bit(input logic [7:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction

   // Reference: what the consumer should see for one frame.
   function automatic logic [9:0] model(input logic [7:0] b, input logic pflip,
                                        input logic s1, input logic s2, input logic two);
      logic perr;
      logic ferr;
      perr = pflip & PAR_EN;
      ferr = ~s1 | (two & ~s2);
      return {perr, ferr, b};
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic pflip, input logic s1,
                             input logic s2, input logic two, input logic odd,
                             input logic flip_cfg, input int tail_low);
      two_stop   = two;
      odd_parity = odd;
      drive_bit(1'b0);
      if (flip_cfg) begin
         two_stop   = ~two;
         odd_parity = ~odd;
      end
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_bit(b, odd) ^ pflip);
`endif
      drive_bit(s1);
      if (two) drive_bit(s2);
      if (tail_low > 0) begin
         rx_in = 1'b0;
         idle(tail_low);
      end
      rx_in = 1'b1;
   endtask

   task automatic expect_word(input string tag, input logic [9:0] exp);
      check({tag, "_count"}, got.size(), 1);
      if (got.size() > 0) check(tag, got.pop_front(), exp);
      got.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       two, odd, pf, s1, s2, fl;

      // Reset state
      #1;
      check("rst_async_data", rx_data, 8'h00);
      check("rst_async_busy", busy, 1'b0);
      idle(3);
      rst_n = 1'b1;
      idle(4);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_data", rx_data, 8'h00);
      check("rst_flags", {parity_err, frame_err, overrun, busy}, 4'h0);

      // Even parity, one stop, clean byte
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idle(20);
      expect_word("a5_even", model(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0));
      check("a5_valid_pulse", rx_valid, 1'b0);

      // Odd parity configured, even-parity bit on the line
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(20);
      expect_word("3c_parity", model(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0));

      // Two stop bits, second one low
      send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(20);
      expect_word("81_frame", model(8'h81, 1'b0, 1'b1, 1'b0, 1'b1));

      // Config flipped mid-frame: two_stop latched at start still applies
      send_frame(8'h6E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      idle(20);
      expect_word("cfg_latched", model(8'h6E, 1'b0, 1'b1, 1'b0, 1'b1));

      // False start: 5 clocks low
      rx_in = 1'b0;
      idle(5);
      check("glitch_busy", busy, 1'b1);
      rx_in = 1'b1;
      idle(30);
      check("glitch_busy_end", busy, 1'b0);
      check("glitch_no_word", got.size(), 0);
      check("glitch_valid", rx_valid, 1'b0);

      // Break: stop low and line held low; exactly one word, no re-trigger
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60);
      check("break_idle_busy", busy, 1'b0);
      idle(40);
      expect_word("break", model(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));

      // Overrun: consumer stalled across two frames
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idle(20);
      check("ovr_first_valid", rx_valid, 1'b1);
      check("ovr_first_data", rx_data, 8'h11);
      check("ovr_first_ferr", frame_err, 1'b1);
      check("ovr_first_flag", overrun, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idle(20);
      check("ovr_held_data", rx_data, 8'h11);
      check("ovr_flag", overrun, 1'b1);
      check("ovr_held_valid", rx_valid, 1'b1);
      rx_ready = 1'b1;
      idle(1);
      rx_ready = 1'b0;
      check("ovr_clear", {rx_valid, parity_err, frame_err, overrun}, 4'h0);
      expect_word("ovr_accepted", model(8'h11, 1'b0, 1'b0, 1'b1, 1'b0));
      rx_ready = 1'b1;

      // Reset during data bit 4 abandons the frame
      two_stop = 1'b0;
      b = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rx_in = b[4];
      idle(5);
      check("abort_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_rst_data", rx_data, 8'h00);
      check("abort_rst_flags", {rx_valid, parity_err, frame_err, overrun, busy}, 5'h00);
      rx_in = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(40);
      check("abort_no_word", got.size(), 0);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idle(20);
      expect_word("after_abort", model(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0));

      // Random frames against the model
      for (int k = 0; k < 16; k++) begin
         b   = 8'($urandom);
         two = 1'($urandom_range(0, 1));
         odd = 1'($urandom_range(0, 1));
         pf  = ($urandom_range(0, 3) == 0);
         s1  = ($urandom_range(0, 4) != 0);
         s2  = ($urandom_range(0, 4) != 0);
         fl  = 1'($urandom_range(0, 1));
         send_frame(b, pf, s1, s2, two, odd, fl, 0);
         idle(20);
         expect_word("random", model(b, pf, s1, s2, two));
         check("random_busy", busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
